pwm_breathe_multi: RTL and testbench



---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_channel.sv | 134 +++++++++++++
 rtl/pwm_breathe_multi.sv | 76 +++++++
 tb/tb_pwm_breathe_multi.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM driver: mode encoding and
// default parameter values used by the top and the per-channel slice.
package pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    localparam int DEF_WIDTH     = 6;
    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_DIV_W     = 10;
    localparam int DEF_DIV_SCALE = 10;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active configuration, step tick counter,
// breathe triangle / blink phase state and the registered output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int DIV_SCALE = DEF_DIV_SCALE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  counter,
    input  logic              boundary,
    input  logic              ena,
    input  logic              wr_en,
    input  logic [MODE_W-1:0] wr_mode,
    input  logic [WIDTH-1:0]  wr_level,
    input  logic [WIDTH-1:0]  wr_rate,
    output logic              pending_valid,
    output logic              pwm_out
);

    localparam logic [WIDTH-1:0] MAX     = '1;
    localparam logic [WIDTH-1:0] MAX_M1  = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [31:0]      SCALE_U = DIV_SCALE;

    mode_e             pend_mode_reg;
    logic [WIDTH-1:0]  pend_level_reg;
    logic [WIDTH-1:0]  pend_rate_reg;
    logic              pend_valid_reg;

    mode_e             act_mode_reg;
    logic [WIDTH-1:0]  act_level_reg;
    logic [WIDTH-1:0]  act_rate_reg;

    logic [DIV_W-1:0]  tick_reg, tick_next;
    logic [WIDTH-1:0]  tri_reg, tri_next;
    logic              dir_down_reg, dir_down_next;
    logic              blink_phase_reg, blink_phase_next;
    logic              pwm_reg;

    logic [DIV_W-1:0]  div;
    logic              step;
    logic              apply;
    logic              mode_changed;
    logic [WIDTH-1:0]  duty;

    // Product is formed at 32 bits and deliberately truncated to the divisor width.
    assign div          = DIV_W'(32'(act_rate_reg) * SCALE_U);
    assign step         = (tick_reg == div);
    assign apply        = boundary & pend_valid_reg;
    assign mode_changed = (pend_mode_reg != act_mode_reg);

    always_comb begin
        tick_next        = step ? '0 : tick_reg + 1'b1;
        tri_next         = tri_reg;
        dir_down_next    = dir_down_reg;
        blink_phase_next = blink_phase_reg;
        if (step) begin
            case (act_mode_reg)
                MODE_BREATHE: begin
                    if (!dir_down_reg) begin
                        tri_next = tri_reg + 1'b1;
                        if (tri_reg == MAX_M1) dir_down_next = 1'b1;
                    end else begin
                        tri_next = tri_reg - 1'b1;
                        if (tri_reg == ONE) dir_down_next = 1'b0;
                    end
                end
                MODE_BLINK: blink_phase_next = ~blink_phase_reg;
                default: ;
            endcase
        end
        // A mode change restarts the animation from a known state.
        if (apply && mode_changed) begin
            tick_next        = '0;
            tri_next         = '0;
            dir_down_next    = 1'b0;
            blink_phase_next = 1'b0;
        end
    end

    always_comb begin
        duty = '0;
        case (act_mode_reg)
            MODE_STATIC:  duty = act_level_reg;
            MODE_BREATHE: duty = tri_reg;
            MODE_BLINK:   duty = blink_phase_reg ? act_level_reg : '0;
            default:      duty = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_mode_reg   <= MODE_OFF;
            pend_level_reg  <= '0;
            pend_rate_reg   <= '0;
            pend_valid_reg  <= 1'b0;
            act_mode_reg    <= MODE_OFF;
            act_level_reg   <= '0;
            act_rate_reg    <= '0;
            tick_reg        <= '0;
            tri_reg         <= '0;
            dir_down_reg    <= 1'b0;
            blink_phase_reg <= 1'b0;
            pwm_reg         <= 1'b0;
        end else begin
            tick_reg        <= tick_next;
            tri_reg         <= tri_next;
            dir_down_reg    <= dir_down_next;
            blink_phase_reg <= blink_phase_next;
            pwm_reg         <= ena & ((duty > counter) | (duty == MAX));
            if (apply) begin
                act_mode_reg   <= pend_mode_reg;
                act_level_reg  <= pend_level_reg;
                act_rate_reg   <= pend_rate_reg;
                pend_valid_reg <= 1'b0;
            end
            // Writes are only strobed while pending is empty, so this never
            // overlaps an apply of older data.
            if (wr_en) begin
                pend_mode_reg  <= mode_e'(wr_mode);
                pend_level_reg <= wr_level;
                pend_rate_reg  <= wr_rate;
                pend_valid_reg <= 1'b1;
            end
        end
    end

    assign pending_valid = pend_valid_reg;
    assign pwm_out       = pwm_reg;

endmodule

// File: rtl/pwm_breathe_multi.sv
// Multi-channel PWM LED driver: shared free-running counter, period_start
// pulse, config ready mux and one pwm_channel per output.
module pwm_breathe_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int DIV_SCALE = DEF_DIV_SCALE,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [WIDTH-1:0]    cfg_level,
    input  logic [WIDTH-1:0]    cfg_rate,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    logic [WIDTH-1:0]    counter_reg;
    logic                period_start_reg;
    logic                boundary;
    logic [CHANNELS-1:0] pending_valid;
    logic [CHANNELS-1:0] wr_en;

    assign boundary = (counter_reg == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_reg      <= '0;
            period_start_reg <= 1'b0;
        end else begin
            counter_reg      <= counter_reg + 1'b1;
            period_start_reg <= (counter_reg == '0);
        end
    end

    // Channel numbers with no channel behind them stay ready, so such
    // writes are accepted and simply go nowhere.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pending_valid[i];
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_ch
        assign wr_en[gi] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(gi));

        pwm_channel #(
            .WIDTH     (WIDTH),
            .DIV_W     (DIV_W),
            .DIV_SCALE (DIV_SCALE)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .counter       (counter_reg),
            .boundary      (boundary),
            .ena           (ena),
            .wr_en         (wr_en[gi]),
            .wr_mode       (cfg_mode),
            .wr_level      (cfg_level),
            .wr_rate       (cfg_rate),
            .pending_valid (pending_valid[gi]),
            .pwm_out       (pwm_out[gi])
        );
    end

    assign period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Directed bench for pwm_breathe_multi: static duty, ena gating, handshake
// stalls, boundary-cycle writes, blink, breathe timing and mid-run reset.
module tb_pwm_breathe_multi;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [5:0] cfg_level;
    logic [5:0] cfg_rate;
    logic [3:0] pwm_out;
    logic       period_start;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt_arr [4];
    int   k = 0;
    logic rdy;
    logic [5:0] tb_cnt;

    pwm_breathe_multi dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_level    (cfg_level),
        .cfg_rate     (cfg_rate),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    // Reference copy of the shared counter, read at negedges.
    always @(posedge clk) begin
        if (!rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 6'd1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = (v - int'(tb_cnt) + 64) % 64;
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                             input logic [5:0] level, input logic [5:0] rate,
                             output logic ready_seen);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_level = level;
        cfg_rate  = rate;
        #1 ready_seen = cfg_ready;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Counts high samples per channel over 64 consecutive cycles.
    task automatic measure();
        for (int c = 0; c < 4; c++) cnt_arr[c] = 0;
        repeat (64) begin
            for (int c = 0; c < 4; c++) cnt_arr[c] += int'(pwm_out[c]);
            @(negedge clk);
        end
    endtask

    task automatic goto_k(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_mode  = 2'd0;
        cfg_level = 6'd0;
        cfg_rate  = 6'd0;
        repeat (3) @(negedge clk);
        check_val("reset_pwm", 32'(pwm_out), 0);
        check_val("reset_period_start", 32'(period_start), 0);
        check_val("reset_ready", 32'(cfg_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("period_start_hi", 32'(period_start), 1);
        @(negedge clk);
        check_val("period_start_lo", 32'(period_start), 0);

        // Static duty 16 on ch0, held back until the boundary.
        wait_cnt(5);
        cfg_write(2'd0, MODE_STATIC, 6'd16, 6'd0, rdy);
        check_val("st16_accept", 32'(rdy), 1);
        wait_cnt(30);
        check_val("st16_ready_busy", 32'(cfg_ready), 0);
        check_val("st16_not_yet", 32'(pwm_out[0]), 0);
        wait_cnt(63);
        check_val("st16_boundary_old", 32'(pwm_out[0]), 0);
        wait_cnt(0);
        check_val("st16_ready_back", 32'(cfg_ready), 1);
        check_val("st16_cnt0", 32'(pwm_out[0]), 0);
        @(negedge clk);
        measure();
        check_val("st16_highs", cnt_arr[0], 16);
        wait_cnt(16);
        check_val("st16_last_high", 32'(pwm_out[0]), 1);
        @(negedge clk);
        check_val("st16_first_low", 32'(pwm_out[0]), 0);

        // Duty 0 and duty MAX extremes, then ena gating.
        cfg_write(2'd1, MODE_STATIC, 6'd0, 6'd0, rdy);
        check_val("st0_accept", 32'(rdy), 1);
        cfg_write(2'd2, MODE_STATIC, 6'd63, 6'd0, rdy);
        check_val("st63_accept", 32'(rdy), 1);
        wait_cnt(1);
        measure();
        check_val("st0_highs", cnt_arr[1], 0);
        check_val("st63_highs", cnt_arr[2], 64);
        ena = 1'b0;
        @(negedge clk);
        check_val("ena_off_all", 32'(pwm_out), 0);
        ena = 1'b1;
        @(negedge clk);
        check_val("ena_on_ch2", 32'(pwm_out[2]), 1);
        check_val("ena_on_ch0", 32'(pwm_out[0]), 1);

        // Second write to a busy channel stalls until after the boundary.
        wait_cnt(5);
        cfg_write(2'd0, MODE_STATIC, 6'd32, 6'd0, rdy);
        check_val("dbl_first_accept", 32'(rdy), 1);
        wait_cnt(10);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_mode  = MODE_STATIC;
        cfg_level = 6'd48;
        #1 check_val("dbl_stall", 32'(cfg_ready), 0);
        wait_cnt(63);
        check_val("dbl_stall_boundary", 32'(cfg_ready), 0);
        wait_cnt(0);
        check_val("dbl_ready_after", 32'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        measure();
        check_val("dbl_first_highs", cnt_arr[0], 32);
        measure();
        check_val("dbl_second_highs", cnt_arr[0], 48);

        // Write landing in the boundary cycle waits a whole period.
        wait_cnt(63);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_mode  = MODE_STATIC;
        cfg_level = 6'd8;
        #1 check_val("bnd_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check_val("bnd_pending", 32'(cfg_ready), 0);
        @(negedge clk);
        measure();
        check_val("bnd_not_current", cnt_arr[1], 0);
        measure();
        check_val("bnd_next_highs", cnt_arr[1], 8);

        // Blink at rate 0: phase flips every clock.
        cfg_write(2'd0, MODE_BLINK, 6'd63, 6'd0, rdy);
        check_val("blink_accept", 32'(rdy), 1);
        wait_cnt(0);
        k = 0;
        goto_k(1);
        check_val("blink_k1", 32'(pwm_out[0]), 0);
        goto_k(2);
        check_val("blink_k2", 32'(pwm_out[0]), 1);
        goto_k(3);
        check_val("blink_k3", 32'(pwm_out[0]), 0);
        goto_k(4);
        check_val("blink_k4", 32'(pwm_out[0]), 1);

        // Breathe on ch3, rate 1 -> one step per 11 clocks.
        cfg_write(2'd3, MODE_BREATHE, 6'd0, 6'd1, rdy);
        check_val("br_accept", 32'(rdy), 1);
        wait_cnt(0);
        k = 0;
        goto_k(10);
        check_val("br_tri_k10", 32'(dut.gen_ch[3].u_ch.tri_reg), 0);
        goto_k(11);
        check_val("br_tri_k11", 32'(dut.gen_ch[3].u_ch.tri_reg), 1);
        goto_k(692);
        check_val("br_tri_k692", 32'(dut.gen_ch[3].u_ch.tri_reg), 62);
        goto_k(693);
        check_val("br_tri_peak", 32'(dut.gen_ch[3].u_ch.tri_reg), 63);
        goto_k(700);
        check_val("br_pwm_at_peak", 32'(pwm_out[3]), 1);
        goto_k(704);
        check_val("br_tri_k704", 32'(dut.gen_ch[3].u_ch.tri_reg), 62);
        goto_k(1385);
        check_val("br_tri_k1385", 32'(dut.gen_ch[3].u_ch.tri_reg), 1);
        goto_k(1386);
        check_val("br_tri_floor", 32'(dut.gen_ch[3].u_ch.tri_reg), 0);
        goto_k(1397);
        check_val("br_tri_rise", 32'(dut.gen_ch[3].u_ch.tri_reg), 1);

        // Reset mid-breathe with a pending write that must be discarded.
        cfg_write(2'd3, MODE_STATIC, 6'd63, 6'd0, rdy);
        check_val("rst_pend_accept", 32'(rdy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_pwm", 32'(pwm_out), 0);
        check_val("rst_ready", 32'(cfg_ready), 1);
        check_val("rst_tri", 32'(dut.gen_ch[3].u_ch.tri_reg), 0);
        rst_n = 1'b1;
        wait_cnt(1);
        measure();
        check_val("rst_drop_ch3", cnt_arr[3], 0);
        check_val("rst_drop_ch2", cnt_arr[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
